hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the five-stage core.
- Drives the write-enables of the F/D registers and the write-enable/flush of the D->E pipeline register, i.e. the control end of the E register interface.
- Detects RAW stalls from Tuse/Tnew comparison against instructions in E and M.
- Tracks multiply/divide unit occupancy with a busy counter, and keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu starts in E (1..15)
- DIV_CYCLES, 10, busy cycles after a div/divu starts in E (1..15)

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  reset, asynchronous, active-low (0 = reset)
- D_rs  in  5  rs field of the instruction in D
- D_rt  in  5  rt field of the instruction in D
- D_tuse_rs  in  2  cycles until D needs rs (0,1,2; 3 = rs unused)
- D_tuse_rt  in  2  cycles until D needs rt (0,1,2; 3 = rt unused)
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_A3  in  5  destination register of the instruction in E (0 = none)
- E_tnew  in  2  cycles until E result is ready (0..2)
- M_A3  in  5  destination register of the instruction in M (0 = none)
- M_tnew  in  2  cycles until M result is ready (0..1; 2 treated as 1)
- E_md_start  in  1  mult/div in E starts the MDU this cycle
- E_md_op  in  1  0 = multiply class, 1 = divide class (valid with E_md_start)
- F_WE  out  1  PC write-enable
- D_WE  out  1  D register write-enable
- E_WE  out  1  E register write-enable
- E_flush  out  1  clear E register to a bubble (all-zero command)
- md_busy  out  1  MDU occupied
- busy_cnt  out  4  remaining MDU busy cycles
- stall_cnt  out  32  total stalled cycles since reset, saturating

Behaviour:
- Reset (res=0, async): busy_cnt=0, md_busy=0, stall_cnt=0. While res=0: F_WE=0, D_WE=0, E_WE=1, E_flush=1.
- stall_rs = (D_tuse_rs!=3) && (D_rs!=0) && (((D_rs==E_A3) && (E_tnew>D_tuse_rs)) || ((D_rs==M_A3) && (M_tnew>D_tuse_rs))).
- stall_rt: same rule using D_rt and D_tuse_rt.
- stall_md = D_is_md && (md_busy || E_md_start).
- stall = stall_rs | stall_rt | stall_md. This path is combinational, with zero latency from inputs to outputs.
- stall=1: F_WE=0, D_WE=0, E_flush=1, E_WE=1, so a bubble is inserted into E and F/D hold.
- stall=0: F_WE=1, D_WE=1, E_flush=0, E_WE=1.
- E_WE is 1 whenever res=1.
- Register 0 never causes a stall, whatever the A3/Tnew values.
- MDU counter, on each rising edge with res=1:
  - E_md_start=1: busy_cnt loads MULT_CYCLES (E_md_op=0) or DIV_CYCLES (E_md_op=1). This takes priority over decrement, and a start while busy restarts the count.
  - else if busy_cnt!=0: busy_cnt decrements by 1.
  - else: busy_cnt holds at 0.
- md_busy = (busy_cnt!=0). It is registered-derived and does not include E_md_start; E_md_start is covered directly in stall_md.
- Timing: with start at edge-cycle T, md_busy is high for cycles T+1..T+N and low at T+N+1, where N is the loaded cycle count.
- stall_cnt increments by 1 on each edge where stall=1 and res=1. It saturates at 0xFFFFFFFF with no wrap.
- Reset asserted mid-count clears busy_cnt and stall_cnt immediately, without waiting for a clock edge.

Test Plan:
- Reset: res=0 -> busy_cnt=0, stall_cnt=0, F_WE=0, D_WE=0, E_flush=1. Release res=1 with all inputs 0 -> F_WE=1, D_WE=1, E_flush=0, E_WE=1.
- Load-use: D_rs=5, D_tuse_rs=0, E_A3=5, E_tnew=2 -> stall (F_WE=0, E_flush=1). Change to E_tnew=0 -> no stall. Change to D_rs=0 with E_A3=0 -> no stall.
- M-stage hazard: D_rt=9, D_tuse_rt=0, M_A3=9, M_tnew=1 -> stall. Change to D_tuse_rt=1 -> no stall. Change to D_tuse_rt=3 -> no stall.
- Multiply: E_md_start=1, E_md_op=0 for one cycle -> busy_cnt reads 5,4,3,2,1,0 on successive cycles. With D_is_md=1 held, the stall lasts 6 cycles (start cycle + 5) and stall_cnt=6.
- Divide restart: divide start (busy_cnt=10), then after 3 decrements (busy_cnt=7) a multiply start -> busy_cnt=5. Assert res=0 mid-count -> busy_cnt=0 before the next edge.
- Saturation: force stall_cnt near max, e.g. run with stall held from preload 0xFFFFFFFE -> reads 0xFFFFFFFF and stays 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: RAW stalls from Tuse/Tnew,
// MDU occupancy stalls, and a saturating stalled-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        res,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_op,
  output logic        F_WE,
  output logic        D_WE,
  output logic        E_WE,
  output logic        E_flush,
  output logic        md_busy,
  output logic [3:0]  busy_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [3:0]  busy_cnt_q, busy_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]  m_tnew_eff;
  logic        stall_rs, stall_rt, stall_md, stall;

  // M can have at most one cycle left; clamp anything larger to 1.
  assign m_tnew_eff = (M_tnew != 2'd0) ? 2'd1 : 2'd0;

  assign stall_rs = (D_tuse_rs != 2'd3) && (D_rs != 5'd0) &&
                    (((D_rs == E_A3) && (E_tnew > D_tuse_rs)) ||
                     ((D_rs == M_A3) && (m_tnew_eff > D_tuse_rs)));
  assign stall_rt = (D_tuse_rt != 2'd3) && (D_rt != 5'd0) &&
                    (((D_rt == E_A3) && (E_tnew > D_tuse_rt)) ||
                     ((D_rt == M_A3) && (m_tnew_eff > D_tuse_rt)));

  assign md_busy  = (busy_cnt_q != 4'd0);
  assign stall_md = D_is_md && (md_busy || E_md_start);
  assign stall    = stall_rs | stall_rt | stall_md;

  // In reset the front end holds and E is loaded with a bubble.
  assign F_WE    = res & ~stall;
  assign D_WE    = res & ~stall;
  assign E_WE    = 1'b1;
  assign E_flush = ~res | stall;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (E_md_start)              busy_cnt_d = E_md_op ? DIV_LD : MULT_LD;
    else if (busy_cnt_q != 4'd0) busy_cnt_d = busy_cnt_q - 4'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      busy_cnt_q  <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_cnt  = busy_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic        D_is_md, E_md_start, E_md_op;
  logic        F_WE, D_WE, E_WE, E_flush, md_busy;
  logic [3:0]  busy_cnt;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .res(res),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .E_A3(E_A3), .E_tnew(E_tnew), .M_A3(M_A3), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_op(E_md_op),
    .F_WE(F_WE), .D_WE(D_WE), .E_WE(E_WE), .E_flush(E_flush),
    .md_busy(md_busy), .busy_cnt(busy_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        f_we, d_we, e_we, e_flush, md_busy;
    logic [3:0]  busy_cnt;
    logic [31:0] stall_cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic clear_in();
    D_rs = 0; D_rt = 0; D_tuse_rs = 0; D_tuse_rt = 0; D_is_md = 0;
    E_A3 = 0; E_tnew = 0; M_A3 = 0; M_tnew = 0; E_md_start = 0; E_md_op = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // stall=1 means F/D hold and a bubble goes into E
  task automatic expect_o(input string name, input logic stl, input logic [3:0] bc,
                          input logic [31:0] sc);
    exp_t e;
    e.name = name; e.f_we = ~stl; e.d_we = ~stl; e.e_we = 1'b1; e.e_flush = stl;
    e.busy_cnt = bc; e.md_busy = (bc != 4'd0); e.stall_cnt = sc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (F_WE === e.f_we && D_WE === e.d_we && E_WE === e.e_we && E_flush === e.e_flush &&
          md_busy === e.md_busy && busy_cnt === e.busy_cnt && stall_cnt === e.stall_cnt)
        n_pass++;
      else
        $display("FAIL %s: got F=%b D=%b EWE=%b fl=%b mb=%b bc=%0d sc=%h, want F=%b D=%b EWE=%b fl=%b mb=%b bc=%0d sc=%h",
                 e.name, F_WE, D_WE, E_WE, E_flush, md_busy, busy_cnt, stall_cnt,
                 e.f_we, e.d_we, e.e_we, e.e_flush, e.md_busy, e.busy_cnt, e.stall_cnt);
    end
  end

  initial begin
    clear_in();
    res = 1'b0;
    step(); expect_o("reset", 1, 0, 0);
    step(); res = 1'b1; expect_o("release", 0, 0, 0);

    // RAW against E and M
    step(); D_rs = 5; E_A3 = 5; E_tnew = 2;             expect_o("loaduse_E", 1, 0, 0);
    step(); E_tnew = 0;                                 expect_o("E_tnew0", 0, 0, 1);
    step(); D_rs = 0; E_A3 = 0; E_tnew = 2;             expect_o("reg0", 0, 0, 1);
    step(); clear_in(); D_rt = 9; M_A3 = 9; M_tnew = 1; expect_o("M_rt", 1, 0, 1);
    step(); D_tuse_rt = 1;                              expect_o("M_tuse1", 0, 0, 2);
    step(); D_tuse_rt = 3; M_tnew = 2;                  expect_o("rt_unused", 0, 0, 2);
    step(); D_tuse_rt = 1;                              expect_o("M_tnew2", 0, 0, 2);
    step(); clear_in(); D_rt = 7; E_A3 = 7; E_tnew = 1; expect_o("E_rt", 1, 0, 2);

    // multiply: 6 stalled cycles
    step(); clear_in(); D_is_md = 1; E_md_start = 1;    expect_o("mult_start", 1, 0, 3);
    step(); E_md_start = 0;                             expect_o("mult5", 1, 5, 4);
    step();                                             expect_o("mult4", 1, 4, 5);
    step();                                             expect_o("mult3", 1, 3, 6);
    step();                                             expect_o("mult2", 1, 2, 7);
    step();                                             expect_o("mult1", 1, 1, 8);
    step();                                             expect_o("mult0", 0, 0, 9);

    // divide, then restart with a multiply while busy
    step(); D_is_md = 0; E_md_start = 1; E_md_op = 1;   expect_o("div_start", 0, 0, 9);
    step(); E_md_start = 0;                             expect_o("div10", 0, 10, 9);
    step();                                             expect_o("div9", 0, 9, 9);
    step();                                             expect_o("div8", 0, 8, 9);
    step(); E_md_start = 1; E_md_op = 0;                expect_o("restart_at7", 0, 7, 9);
    step(); E_md_start = 0;                             expect_o("restart5", 0, 5, 9);
    step();                                             expect_o("restart4", 0, 4, 9);
    step(); res = 1'b0;                                 expect_o("async_rst", 1, 0, 0);
    step(); res = 1'b1;                                 expect_o("post_rst", 0, 0, 0);

    // saturation from a preloaded count
    step(); D_rs = 5; E_A3 = 5; E_tnew = 2;
    force dut.stall_cnt_q = 32'hFFFF_FFFE; #1; release dut.stall_cnt_q;
    expect_o("preload", 1, 0, 32'hFFFF_FFFE);
    step();                                             expect_o("sat_max", 1, 0, 32'hFFFF_FFFF);
    step();                                             expect_o("sat_hold", 1, 0, 32'hFFFF_FFFF);
    step(); clear_in();                                 expect_o("sat_idle", 0, 0, 32'hFFFF_FFFF);

    @(negedge clk); #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
